// File: rtl/pulse_monitor_pkg.sv
// Shared FSM encoding and default configuration for the pulse period monitor.
package pulse_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MEASURE   = 2'd1,
    ST_TIMED_OUT = 2'd2
  } state_e;

  localparam int          DEF_CNT_WIDTH       = 32;
  localparam logic [31:0] DEF_EXPECTED_PERIOD = 32'd10000000;
  localparam logic [31:0] DEF_TOLERANCE       = 32'd16;
  localparam logic [31:0] DEF_TIMEOUT         = 32'd20000000;
  localparam int          DEF_LOCK_COUNT      = 4;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge detector.
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic meta_q;
  logic sync_q;
  logic sync_dly_q;
  logic rise_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      sync_dly_q <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      meta_q     <= i_async;
      sync_q     <= meta_q;
      sync_dly_q <= sync_q;
      rise_q     <= sync_q & ~sync_dly_q;
    end
  end

  assign o_rise = rise_q;

endmodule

// File: rtl/pulse_period_monitor.sv
// Measures the period between rising edges of an asynchronous pulse, flags
// in-range periods, tracks lock and declares a timeout when edges stop.
module pulse_period_monitor
  import pulse_monitor_pkg::*;
#(
  parameter int          CNT_WIDTH       = DEF_CNT_WIDTH,
  parameter logic [31:0] EXPECTED_PERIOD = DEF_EXPECTED_PERIOD,
  parameter logic [31:0] TOLERANCE       = DEF_TOLERANCE,
  parameter logic [31:0] TIMEOUT         = DEF_TIMEOUT,
  parameter int          LOCK_COUNT      = DEF_LOCK_COUNT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pulse,
  output logic [CNT_WIDTH-1:0] o_period,
  output logic                 o_valid,
  output logic                 o_in_range,
  output logic                 o_timeout,
  output logic                 o_locked
);

  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH:0]   EXP_W    = (CNT_WIDTH + 1)'(EXPECTED_PERIOD);
  localparam logic [CNT_WIDTH:0]   TOL_W    = (CNT_WIDTH + 1)'(TOLERANCE);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT - 32'd1);
  localparam logic [LW-1:0]        LOCK_MAX = LW'(LOCK_COUNT);

  if ((TIMEOUT <= ({1'b0, EXPECTED_PERIOD} + {1'b0, TOLERANCE})) ||
      ((TIMEOUT >> CNT_WIDTH) != 32'd0) || (LOCK_COUNT < 1)) begin : g_bad_cfg
    $error("pulse_period_monitor: TIMEOUT/LOCK_COUNT configuration is invalid");
  end

  logic rise;

  sync_edge_detect u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_pulse),
    .o_rise  (rise)
  );

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [LW-1:0]        lock_q;
  logic [CNT_WIDTH-1:0] period_q;
  logic                 valid_q;
  logic                 in_range_q;
  logic                 timeout_q;
  logic                 locked_q;

  logic [CNT_WIDTH-1:0] period_d;
  logic [CNT_WIDTH:0]   period_ext;
  logic [CNT_WIDTH:0]   diff_d;
  logic                 in_range_d;
  logic [LW-1:0]        lock_d;

  // The extra MSB keeps the deviation from wrapping for periods below nominal.
  always_comb begin
    period_d   = cnt_q + CNT_WIDTH'(1);
    period_ext = {1'b0, period_d};
    diff_d     = (period_ext >= EXP_W) ? (period_ext - EXP_W) : (EXP_W - period_ext);
    in_range_d = (diff_d <= TOL_W);
    lock_d     = '0;
    if (in_range_d) begin
      lock_d = (lock_q == LOCK_MAX) ? lock_q : lock_q + LW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      lock_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      in_range_q <= 1'b0;
      timeout_q  <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (rise) begin
            state_q <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            period_q   <= period_d;
            in_range_q <= in_range_d;
            valid_q    <= 1'b1;
            lock_q     <= lock_d;
            locked_q   <= (lock_d == LOCK_MAX);
            cnt_q      <= '0;
          end else if (cnt_q == TMO_LAST) begin
            state_q   <= ST_TIMED_OUT;
            timeout_q <= 1'b1;
            lock_q    <= '0;
            locked_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_TIMED_OUT: begin
          // The interval ending at this edge has unknown start, so no strobe.
          if (rise) begin
            state_q   <= ST_MEASURE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign o_period   = period_q;
  assign o_valid    = valid_q;
  assign o_in_range = in_range_q;
  assign o_timeout  = timeout_q;
  assign o_locked   = locked_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Scoreboard bench: edge stimulus queues expected strobes, a monitor pops them.
module tb_pulse_period_monitor;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_pulse;
  logic [31:0] o_period;
  logic        o_valid;
  logic        o_in_range;
  logic        o_timeout;
  logic        o_locked;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int cyc;
    int per;
    bit inr;
    bit lk;
  } exp_t;

  exp_t sb_q[$];

  pulse_period_monitor #(
    .CNT_WIDTH       (32),
    .EXPECTED_PERIOD (32'd100),
    .TOLERANCE       (32'd2),
    .TIMEOUT         (32'd300),
    .LOCK_COUNT      (4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_pulse    (i_pulse),
    .o_period   (o_period),
    .o_valid    (o_valid),
    .o_in_range (o_in_range),
    .o_timeout  (o_timeout),
    .o_locked   (o_locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (o_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid at cycle %0d: actual period=%0d expected no strobe",
                 cyc, o_period);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("period", o_period, e.per);
        chk("in_range", o_in_range, e.inr);
        chk("locked", o_locked, e.lk);
        chk("timeout_at_strobe", o_timeout, 0);
        $display("strobe cycle=%0d period=%0d in_range=%0b locked=%0b", cyc, o_period,
                 o_in_range, o_locked);
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    goto(c);
    @(negedge clk);
  endtask

  task automatic edge_at(input int c, input int hi, input bit expv, input int per,
                         input bit inr, input bit lk);
    goto(c);
    i_pulse = 1'b1;
    if (expv) sb_q.push_back('{cyc: c + 4, per: per, inr: inr, lk: lk});
    repeat (hi) begin
      @(posedge clk);
      #1;
    end
    i_pulse = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int t;
    int c8;
    int c9;
    int c10;
    int c11;
    i_rst   = 1'b1;
    i_pulse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_period", o_period, 0);
    chk("reset_valid", o_valid, 0);
    chk("reset_in_range", o_in_range, 0);
    chk("reset_timeout", o_timeout, 0);
    chk("reset_locked", o_locked, 0);
    i_rst = 1'b0;

    // Steady 100-cycle single-cycle pulses: 6 edges, 5 strobes, lock on 4th.
    t = cyc + 2;
    edge_at(t, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) edge_at(t + 100 * k, 1, 1, 100, 1, k >= 4);

    // Reset 50 cycles into the next interval must clear everything at once.
    goto(t + 550);
    #2;
    i_rst = 1'b1;
    #1;
    chk("midreset_period", o_period, 0);
    chk("midreset_valid", o_valid, 0);
    chk("midreset_in_range", o_in_range, 0);
    chk("midreset_timeout", o_timeout, 0);
    chk("midreset_locked", o_locked, 0);
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;

    // 100,100,100,103 then 4 x 98.
    t = cyc + 2;
    edge_at(t, 1, 0, 0, 0, 0);
    edge_at(t + 100, 1, 1, 100, 1, 0);
    edge_at(t + 200, 1, 1, 100, 1, 0);
    edge_at(t + 300, 1, 1, 100, 1, 0);
    edge_at(t + 403, 1, 1, 103, 0, 0);
    edge_at(t + 501, 1, 1, 98, 1, 0);
    edge_at(t + 599, 1, 1, 98, 1, 0);
    edge_at(t + 697, 1, 1, 98, 1, 0);
    edge_at(t + 795, 1, 1, 98, 1, 1);

    // Locked, then silence: timeout lands 300 cycles after the strobe.
    c8 = t + 795;
    at_neg(c8 + 303);
    chk("timeout_not_yet", o_timeout, 0);
    chk("locked_before_timeout", o_locked, 1);
    at_neg(c8 + 304);
    chk("timeout_set", o_timeout, 1);
    chk("locked_cleared_by_timeout", o_locked, 0);
    chk("period_held_in_timeout", o_period, 98);
    chk("in_range_held_in_timeout", o_in_range, 1);

    c9 = c8 + 310;
    edge_at(c9, 1, 0, 0, 0, 0);
    at_neg(c9 + 3);
    chk("timeout_before_recover", o_timeout, 1);
    at_neg(c9 + 4);
    chk("timeout_cleared", o_timeout, 0);

    c10 = c9 + 100;
    edge_at(c10, 1, 1, 100, 1, 0);

    // Edge exactly TIMEOUT cycles later: edge wins over timeout.
    c11 = c10 + 300;
    edge_at(c11, 1, 1, 300, 0, 0);
    at_neg(c11 + 4);
    chk("boundary_no_timeout", o_timeout, 0);
    at_neg(c11 + 5);
    chk("boundary_no_timeout_after", o_timeout, 0);

    // 50% duty square wave at period 100: only rising edges count.
    for (int k = 1; k <= 4; k++) edge_at(c11 + 100 * k, 50, 1, 100, 1, k == 4);

    goto(cyc + 60);
    chk("pending_strobes", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_period_monitor.md
PULSE_PERIOD_MONITOR -- requirements
Module: pulse_period_monitor

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, meaning width of the period counter and of o_period.
REQ-002 SHALL have parameter EXPECTED_PERIOD, default 32'd10000000, meaning the nominal pulse period in i_clk cycles.
REQ-003 SHALL have parameter TOLERANCE, default 32'd16, meaning the allowed absolute deviation from EXPECTED_PERIOD in cycles.
REQ-004 SHALL have parameter TIMEOUT, default 32'd20000000, meaning the number of cycles without an edge before a timeout is declared.
REQ-005 SHALL have parameter LOCK_COUNT, default 4, meaning the number of consecutive in-range periods required to assert lock.
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-007 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port i_pulse, input, 1 bit: pulse/LED-drive signal, asynchronous to i_clk.
REQ-009 SHALL have port o_period, output, CNT_WIDTH bits: last measured period in cycles.
REQ-010 SHALL have port o_valid, output, 1 bit: one-cycle strobe, high when o_period/o_in_range update.
REQ-011 SHALL have port o_in_range, output, 1 bit: last period within EXPECTED_PERIOD +/- TOLERANCE.
REQ-012 SHALL have port o_timeout, output, 1 bit: level, no edge seen for TIMEOUT cycles.
REQ-013 SHALL have port o_locked, output, 1 bit: level, LOCK_COUNT consecutive in-range periods seen.

Function
REQ-014 i_pulse SHALL pass a 2-flop synchronizer; a rising edge SHALL be detected when the synchronized value is 1 and its one-cycle-delayed copy is 0.
REQ-015 FSM states SHALL be IDLE (no edge yet), MEASURE (counting between edges) and TIMED_OUT.
REQ-016 IDLE: counter held at 0; on edge -> MEASURE, counter cleared, no o_valid.
REQ-017 MEASURE: counter increments by 1 each cycle without an edge; on edge o_period <= counter+1, counter <= 0, o_valid high for exactly the next cycle.
REQ-018 Edges spaced N cycles apart SHALL yield o_period = N; o_valid SHALL rise 4 cycles after the i_pulse rising edge when setup is met at the first synchronizer flop.
REQ-019 o_in_range SHALL update with o_valid: 1 iff |o_period - EXPECTED_PERIOD| <= TOLERANCE, difference computed in CNT_WIDTH+1 bits with no wrap.
REQ-020 A lock counter SHALL increment (saturating at LOCK_COUNT) on each in-range period, clear on any out-of-range period; o_locked = (lock counter == LOCK_COUNT).
REQ-021 MEASURE with counter == TIMEOUT-1 and no edge -> TIMED_OUT: o_timeout = 1, lock counter cleared, o_locked = 0, counter stops (no wrap).
REQ-022 Edge in the same cycle the counter reaches TIMEOUT-1: edge wins, o_period = TIMEOUT, no timeout.
REQ-023 TIMED_OUT: on edge -> MEASURE, counter cleared, o_timeout cleared next cycle, no o_valid (first interval unknown).
REQ-024 o_period and o_in_range SHALL hold their last values between strobes and across timeout.
REQ-025 TIMEOUT SHALL be > EXPECTED_PERIOD + TOLERANCE and < 2^CNT_WIDTH; violations are a configuration error.

Reset
REQ-026 i_rst high SHALL asynchronously force: state IDLE, counters 0, synchronizer flops 0, o_period 0, o_valid 0, o_in_range 0, o_timeout 0, o_locked 0.
REQ-027 Reset mid-measurement SHALL discard the partial interval; first edge after release behaves as in IDLE.

Structure
REQ-028 The FSM state encoding and the default parameter constants SHALL live in a shared package, pulse_monitor_pkg.
REQ-029 Synchronizer plus rising-edge detector SHALL be one sub-module, sync_edge_detect (ports i_clk, i_rst, i_async, o_rise).

Verification (bench parameters EXPECTED_PERIOD=100, TOLERANCE=2, TIMEOUT=300, LOCK_COUNT=4)
REQ-030 Pulses every 100 cycles, 6 edges -> 5 o_valid strobes, o_period=100, o_in_range=1, o_locked=1 after 4th strobe.
REQ-031 Periods 100,100,100,103 -> 4th strobe o_period=103, o_in_range=0, o_locked stays 0; then 4 x 98 -> o_locked=1.
REQ-032 Locked, then no edge for 300 cycles -> o_timeout=1 and o_locked=0 at cycle 300; next edge -> o_timeout=0, no o_valid; following edge at +100 -> o_period=100.
REQ-033 Edge exactly 300 cycles after previous -> o_valid with o_period=300, o_timeout stays 0.
REQ-034 i_rst asserted 50 cycles into an interval, released -> all outputs 0 immediately; first post-reset edge gives no o_valid, second at +100 gives o_period=100.
REQ-035 Single-cycle glitch-free pulses vs. 50%-duty square wave at period 100 -> identical o_period=100 (only rising edges count).
